// File: rtl/textdisp_console.sv
// Byte-stream console front end for a COLS x ROWS text display: prints characters,
// handles LF/CR/BS/FF, and blanks a line or the whole screen with one write per cycle.
module textdisp_console #(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 28,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic [3:0]  reg_char_we,
    output logic [31:0] reg_char_di,
    output logic [4:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_LINE   = 2'd1,
        CLR_SCREEN = 2'd2
    } state_t;

    localparam logic [4:0] X_LAST = 5'(COLS - 1);
    localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

    state_t      state_q, state_d;
    logic [4:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic [4:0]  clr_x_q, clr_x_d;
    logic [4:0]  clr_y_q, clr_y_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] di_q, di_d;
    logic        busy_q, busy_d;
    logic        accept_s;

    function automatic logic [31:0] pack_word(input logic [4:0] x, input logic [4:0] y,
                                              input logic [7:0] c);
        return {8'h00, 3'b000, x, 3'b000, y, 1'b0, c[6:0]};
    endfunction

    // busy tracks the visible clear writes, so in_ready stays low until the last one has gone out
    assign in_ready    = (state_q == IDLE) && !busy_q && !reset;
    assign accept_s    = in_valid && in_ready;
    assign reg_char_we = we_q;
    assign reg_char_di = di_q;
    assign cursor_x    = cur_x_q;
    assign cursor_y    = cur_y_q;
    assign busy        = busy_q;

    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        clr_x_d = clr_x_q;
        clr_y_d = clr_y_q;
        we_d    = 4'b0000;
        di_d    = di_q;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (in_char >= 8'h20 && in_char != 8'h7F) begin
                        we_d = 4'b0001;
                        di_d = pack_word(cur_x_q, cur_y_q, in_char[7] ? 8'h3F : in_char);
                        if (cur_x_q == X_LAST) begin
                            cur_x_d = 5'd0;
                            cur_y_d = (cur_y_q == Y_LAST) ? 5'd0 : cur_y_q + 5'd1;
                            clr_x_d = 5'd0;
                            state_d = CLR_LINE;
                        end else begin
                            cur_x_d = cur_x_q + 5'd1;
                        end
                    end else begin
                        case (in_char)
                            8'h0A: begin
                                cur_x_d = 5'd0;
                                cur_y_d = (cur_y_q == Y_LAST) ? 5'd0 : cur_y_q + 5'd1;
                                clr_x_d = 5'd0;
                                state_d = CLR_LINE;
                            end
                            8'h0D: cur_x_d = 5'd0;
                            8'h08: begin
                                if (cur_x_q != 5'd0) begin
                                    cur_x_d = cur_x_q - 5'd1;
                                    we_d    = 4'b0001;
                                    di_d    = pack_word(cur_x_q - 5'd1, cur_y_q, BLANK);
                                end else begin
                                    cur_x_d = cur_x_q;
                                end
                            end
                            8'h0C: begin
                                clr_x_d = 5'd0;
                                clr_y_d = 5'd0;
                                state_d = CLR_SCREEN;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CLR_LINE: begin
                we_d   = 4'b0001;
                busy_d = 1'b1;
                di_d   = pack_word(clr_x_q, cur_y_q, BLANK);
                if (clr_x_q == X_LAST) begin
                    state_d = IDLE;
                end else begin
                    clr_x_d = clr_x_q + 5'd1;
                end
            end
            CLR_SCREEN: begin
                we_d   = 4'b0001;
                busy_d = 1'b1;
                di_d   = pack_word(clr_x_q, clr_y_q, BLANK);
                if (clr_x_q == X_LAST) begin
                    clr_x_d = 5'd0;
                    if (clr_y_q == Y_LAST) begin
                        cur_x_d = 5'd0;
                        cur_y_d = 5'd0;
                        state_d = IDLE;
                    end else begin
                        clr_y_d = clr_y_q + 5'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_x_q <= 5'd0;
            cur_y_q <= 5'd0;
            clr_x_q <= 5'd0;
            clr_y_q <= 5'd0;
            we_q    <= 4'b0000;
            di_q    <= 32'h0000_0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            we_q    <= we_d;
            di_q    <= di_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_textdisp_console.sv
// Scoreboard bench for textdisp_console: a cursor/screen model queues expected writes,
// a negedge monitor pops and compares each write the DUT presents.
module tb_textdisp_console;

    localparam int         COLS  = 32;
    localparam int         ROWS  = 28;
    localparam logic [7:0] BLANK = 8'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic [3:0]  reg_char_we;
    logic [31:0] reg_char_di;
    logic [4:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wcount = 0;
    logic [31:0] last_di = 32'h0;
    logic [31:0] exp_q[$];
    int          mx = 0;
    int          my = 0;

    always #5 clk = ~clk;

    textdisp_console #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .reg_char_we(reg_char_we), .reg_char_di(reg_char_di),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int x, input int y, input logic [7:0] c);
        logic [4:0] xb;
        logic [4:0] yb;
        xb = x[4:0];
        yb = y[4:0];
        return {8'h00, 3'b000, xb, 3'b000, yb, 1'b0, c[6:0]};
    endfunction

    // Reference model: cursor position plus the list of display writes each byte causes
    task automatic model_line_adv();
        mx = 0;
        my = (my == ROWS - 1) ? 0 : my + 1;
        for (int i = 0; i < COLS; i++) exp_q.push_back(word(i, my, BLANK));
    endtask

    task automatic model(input logic [7:0] b);
        if ((b >= 8'h20 && b <= 8'h7E) || b >= 8'h80) begin
            exp_q.push_back(word(mx, my, (b >= 8'h80) ? 8'h3F : b));
            if (mx == COLS - 1) model_line_adv();
            else mx = mx + 1;
        end else if (b == 8'h0A) begin
            model_line_adv();
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx = mx - 1;
                exp_q.push_back(word(mx, my, BLANK));
            end
        end else if (b == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) exp_q.push_back(word(c, r, BLANK));
            mx = 0;
            my = 0;
        end
    endtask

    always @(negedge clk) begin
        if (reg_char_we == 4'b0001) begin
            wcount++;
            last_di = reg_char_di;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got di=%h with no write expected", reg_char_di);
            end else begin
                chk("write_di", reg_char_di, exp_q.pop_front());
            end
        end else if (reg_char_we !== 4'b0000) begin
            chk("we_encoding", {28'h0, reg_char_we}, 32'h0);
        end
        if (busy && in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_while_busy: got in_ready=1 busy=1 required in_ready=0");
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = b;
        n = 0;
        while (!in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            $display("FAIL accept_timeout: got in_ready=0 required 1 within 20000 cycles");
            n_bad++;
            n_cmp++;
            in_valid = 1'b0;
        end else begin
            model(b);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        chk("cursor_x", {27'h0, cursor_x}, mx);
        chk("cursor_y", {27'h0, cursor_y}, my);
    endtask

    task automatic send_n(input logic [7:0] b, input int cnt);
        for (int i = 0; i < cnt; i++) send(b);
    endtask

    initial begin
        int w0;
        int bc;
        int n;
        int r;
        int v;
        logic [7:0] b;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", {28'h0, reg_char_we}, 32'h0);
        chk("rst_di", reg_char_di, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_cursor", {22'h0, cursor_x, cursor_y}, 32'h0);
        reset = 1'b0;
        #1 chk("ready_after_reset", {31'h0, in_ready}, 32'h1);

        send(8'h41);
        @(negedge clk);
        chk("A_we", {28'h0, reg_char_we}, 32'h1);
        chk("A_di", reg_char_di, 32'h0000_0041);
        wait_idle();
        chk("A_cursor", {22'h0, cursor_x, cursor_y}, {22'h0, 5'd1, 5'd0});

        send(8'h0C);
        wait_idle();
        send_n(8'h0A, 5);
        send_n(8'h78, 31);
        wait_idle();
        send(8'h42);
        @(negedge clk);
        chk("wrap_di", reg_char_di, 32'h001F_0542);
        bc = 0;
        n = 0;
        while (!in_ready && n < 200) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        chk("wrap_busy_cycles", bc, 32);
        wait_idle();
        chk("wrap_cursor", {22'h0, cursor_x, cursor_y}, {22'h0, 5'd0, 5'd6});

        send_n(8'h0A, 21);
        send_n(8'h79, 7);
        send(8'h0A);
        wait_idle();
        chk("lf_wrap_cursor", {22'h0, cursor_x, cursor_y}, 32'h0);
        send(8'h7A);
        wait_idle();
        w0 = wcount;
        send(8'h0D);
        wait_idle();
        chk("cr_no_write", wcount - w0, 0);

        w0 = wcount;
        send(8'h0C);
        wait_idle();
        chk("ff_write_count", wcount - w0, COLS * ROWS);
        chk("ff_last_di", last_di, 32'h001F_1B20);

        send_n(8'h0A, 3);
        wait_idle();
        w0 = wcount;
        send(8'h08);
        wait_idle();
        chk("bs_at_0_no_write", wcount - w0, 0);
        send_n(8'h61, 4);
        send(8'h08);
        @(negedge clk);
        chk("bs_di", reg_char_di, 32'h0003_0320);
        wait_idle();
        chk("bs_cursor", {22'h0, cursor_x, cursor_y}, {22'h0, 5'd3, 5'd3});

        w0 = wcount;
        send(8'h0C);
        n = 0;
        while (wcount < w0 + 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        mx = 0;
        my = 0;
        @(posedge clk);
        #1 exp_q.delete();
        w0 = wcount;
        repeat (40) @(negedge clk);
        chk("abort_no_writes", wcount - w0, 0);
        chk("abort_cursor", {22'h0, cursor_x, cursor_y}, 32'h0);
        reset = 1'b0;
        send(8'hC8);
        @(negedge clk);
        chk("high_byte_char", {24'h0, reg_char_di[7:0]}, 32'h3F);
        wait_idle();

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(32, 126));
            else if (r < 68) b = 8'h0A;
            else if (r < 74) b = 8'h0D;
            else if (r < 82) b = 8'h08;
            else if (r < 90) b = 8'($urandom_range(128, 255));
            else if (r < 91) b = 8'h0C;
            else begin
                v = $urandom_range(0, 32);
                if (v == 32) b = 8'h7F;
                else if (v == 8 || v == 10 || v == 12 || v == 13) b = 8'h01;
                else b = 8'(v);
            end
            send(b);
            if (i % 25 == 24) wait_idle();
        end
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/textdisp_console.md
TEXTDISP_CONSOLE -- requirements
Module: textdisp_console

Interface
REQ-001 The block SHALL have parameter COLS, default 32, meaning text columns (cursor x range 0..COLS-1).
REQ-002 The block SHALL have parameter ROWS, default 28, meaning text rows (cursor y range 0..ROWS-1).
REQ-003 The block SHALL have parameter BLANK, default 8'h20, meaning the fill character for clears.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; the block SHALL use one clock only.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a byte is offered.
REQ-007 The block SHALL have port in_char, input, 8 bits: the offered byte.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the byte is accepted this cycle when in_valid is also high.
REQ-009 The block SHALL have port reg_char_we, output, 4 bits: write strobe to the text display, 4'b0001 for a write, 4'b0000 otherwise.
REQ-010 The block SHALL have port reg_char_di, output, 32 bits: write word {8'h00, 3'b0, x[4:0], 3'b0, y[4:0], 1'b0, char[6:0]}.
REQ-011 The block SHALL have ports cursor_x, output, 5 bits, and cursor_y, output, 5 bits: the current cursor position.
REQ-012 The block SHALL have port busy, output, 1 bit: a multi-cycle clear is in progress.

Function
REQ-013 The block SHALL implement states IDLE, CLR_LINE and CLR_SCREEN, with busy = (state != IDLE).
REQ-014 in_ready SHALL be high only in IDLE, and low in the cycle reset is asserted.
REQ-015 The block SHALL take one accept per cycle in IDLE, so back-to-back printable bytes yield one write per cycle.
REQ-016 For a printable byte (0x20-0x7E), the cycle after accept SHALL carry we=4'b0001 with char at the pre-accept cursor; all outputs SHALL be registered.
REQ-017 For a byte 0x80-0xFF, the block SHALL write char 0x3F ('?') as for a printable byte.
REQ-018 After a printable write with x<COLS-1, the cursor SHALL advance x+1.
REQ-019 After a printable write at x=COLS-1, the block SHALL perform a line advance.
REQ-020 For 0x0A (LF), the block SHALL perform a line advance with no character write.
REQ-021 Line advance SHALL set x=0 and y=(y==ROWS-1)?0:y+1 (wrap, no scroll), then enter CLR_LINE.
REQ-022 CLR_LINE SHALL issue COLS consecutive BLANK writes to row y, at x=0..COLS-1, one per cycle, then return to IDLE.
REQ-023 For 0x0D (CR), the block SHALL set x=0, with no write and no state change.
REQ-024 For 0x08 (BS) with x>0, the block SHALL set x=x-1 and write BLANK at the new position; at x=0 it SHALL do nothing (no reverse wrap).
REQ-025 For 0x0C (FF), the block SHALL enter CLR_SCREEN and issue COLS*ROWS BLANK writes row-major from (0,0) to (COLS-1,ROWS-1), one per cycle, then set the cursor to (0,0) and return to IDLE.
REQ-026 All other bytes (0x00-0x1F not listed, and 0x7F) SHALL be consumed with no write and no cursor change.
REQ-027 The clear-position counters SHALL use exact terminal compares (x==COLS-1, y==ROWS-1); there SHALL be no extra write and no idle gap inside a clear.
REQ-028 While busy, in_valid SHALL be ignored and the offered byte held by the source, since in_ready is low.
REQ-029 The first clear write SHALL occur in the cycle after the triggering accept (or after the final printable write), and the last clear write SHALL occur in the cycle before in_ready rises.
REQ-030 The cursor outputs SHALL reflect the position that applies to the next accepted byte.

Reset
REQ-031 With reset high at a clock edge: state=IDLE, cursor=(0,0), reg_char_we=0, reg_char_di=0, busy=0, in_ready=0.
REQ-032 Reset SHALL not clear the display.
REQ-033 Reset mid-clear SHALL abort the clear immediately, with no further writes.
REQ-034 In the first cycle after reset deasserts, in_ready SHALL be 1.

Verification
REQ-035 Directed test: after reset, send "A" (0x41) -> next cycle we=1, di=32'h0000_0041, and cursor=(1,0).
REQ-036 Directed test: at cursor (31,5), send 0x42 -> write at (31,5) with di=32'h001F_0542, then 32 BLANK writes to row 6, busy=1 for 32 cycles, and final cursor (0,6).
REQ-037 Directed test: at cursor (7,27), send 0x0A -> 32 BLANK writes to row 0 and cursor (0,0); then 0x0D -> no write.
REQ-038 Directed test: send 0x0C -> exactly 896 writes, the last with di=32'h001F_1B20, in_ready low throughout, and cursor (0,0) after.
REQ-039 Directed test: at (0,3), send 0x08 -> no write; at (4,3), send 0x08 -> BLANK write at (3,3) and cursor (3,3).
REQ-040 Directed test: assert reset after the 100th write of a 0x0C clear -> no further writes, cursor (0,0); after release, send 0xC8 -> di char=0x3F.
